decode_unit: RTL and testbench

DECODE_UNIT -- requirements
Module: decode_unit

---
 rtl/decode_unit.sv | 187 ++++++++++++++++++
 tb/tb_decode_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_unit.sv
// decode_unit: RV32/RV64 base instruction pre-decoder with a small output buffer.
//
// Each incoming instruction is classified and its register indices, operand-use
// flags and sign-extended immediate are extracted combinationally. The decoded
// entry and its pc are pushed into a DEPTH-entry FIFO. The out_* ports always
// show the FIFO head and read as all-zero whenever the FIFO is empty.
//
// Ports
//   clk, rst          clock (rising edge) / asynchronous active-high reset
//   flush             synchronous discard of all buffered entries
//   in_valid/in_ready source handshake carrying in_inst (32b) and in_pc (XLEN)
//   out_valid/out_ready sink handshake for the decoded head entry
//   out_pc, out_imm   head pc and sign-extended immediate (XLEN)
//   out_rs1/rs2/rd    register indices, zeroed when the matching flag is 0
//   out_rs1_en, out_rs2_en, out_rd_we  operand-use / writeback flags
//   out_fmt           R=0 I=1 S=2 B=3 U=4 J=5 illegal=7
//   out_illegal       unrecognised encoding (still delivered as an entry)
module decode_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_rs1_en,
    output logic            out_rs2_en,
    output logic            out_rd_we,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            rs1_en;
        logic            rs2_en;
        logic            rd_we;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    logic [2:0]        fmt_c;
    logic signed [31:0] imm32_c;
    logic              rs1_en_c;
    logic              rs2_en_c;
    logic              rd_we_c;
    entry_t            dec_c;

    // Every recognised opcode ends in 2'b11, so a compressed/non-32-bit
    // encoding (inst[1:0] != 2'b11) falls into the default arm as illegal.
    always_comb begin
        fmt_c = FMT_ILL;
        case (in_inst[6:0])
            7'b0110011:                                     fmt_c = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: fmt_c = FMT_I;
            7'b0100011:                                     fmt_c = FMT_S;
            7'b1100011:                                     fmt_c = FMT_B;
            7'b0110111, 7'b0010111:                         fmt_c = FMT_U;
            7'b1101111:                                     fmt_c = FMT_J;
            default:                                        fmt_c = FMT_ILL;
        endcase
    end

    // All immediates fit in 32 bits; the signed cast below extends to XLEN.
    always_comb begin
        imm32_c = '0;
        case (fmt_c)
            FMT_I: imm32_c = {{20{in_inst[31]}}, in_inst[31:20]};
            FMT_S: imm32_c = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            FMT_B: imm32_c = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                              in_inst[30:25], in_inst[11:8], 1'b0};
            FMT_U: imm32_c = {in_inst[31:12], 12'b0};
            FMT_J: imm32_c = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                              in_inst[20], in_inst[30:21], 1'b0};
            default: imm32_c = '0;
        endcase
    end

    always_comb begin
        rs1_en_c = (fmt_c == FMT_R) || (fmt_c == FMT_I) ||
                   (fmt_c == FMT_S) || (fmt_c == FMT_B);
        rs2_en_c = (fmt_c == FMT_R) || (fmt_c == FMT_S) || (fmt_c == FMT_B);
        rd_we_c  = ((fmt_c == FMT_R) || (fmt_c == FMT_I) ||
                    (fmt_c == FMT_U) || (fmt_c == FMT_J)) && (in_inst[11:7] != 5'd0);

        dec_c         = '0;
        dec_c.pc      = in_pc;
        dec_c.imm     = XLEN'(imm32_c);
        dec_c.rs1     = rs1_en_c ? in_inst[19:15] : 5'd0;
        dec_c.rs2     = rs2_en_c ? in_inst[24:20] : 5'd0;
        dec_c.rd      = rd_we_c  ? in_inst[11:7]  : 5'd0;
        dec_c.rs1_en  = rs1_en_c;
        dec_c.rs2_en  = rs2_en_c;
        dec_c.rd_we   = rd_we_c;
        dec_c.fmt     = fmt_c;
        dec_c.illegal = (fmt_c == FMT_ILL);
    end

    // FIFO control. in_ready/out_valid come straight from the registered count,
    // so there is no combinational path from out_ready to in_ready.
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q,  cnt_d;
    logic          push;
    logic          pop;
    entry_t        mem_q [DEPTH];
    entry_t        head;

    assign in_ready  = (cnt_q < CW'(DEPTH));
    assign out_valid = (cnt_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Entry storage carries no reset; stale contents are masked by out_valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= dec_c;
    end

    assign head        = out_valid ? mem_q[rptr_q] : '0;
    assign out_pc      = head.pc;
    assign out_imm     = head.imm;
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_rd      = head.rd;
    assign out_rs1_en  = head.rs1_en;
    assign out_rs2_en  = head.rs2_en;
    assign out_rd_we   = head.rd_we;
    assign out_fmt     = head.fmt;
    assign out_illegal = head.illegal;

endmodule

// File: tb/tb_decode_unit.sv
module tb_decode_unit;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rs1_en;
        logic        rs2_en;
        logic        rd_we;
        logic [2:0]  fmt;
        logic        illegal;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic        in_valid_a, in_valid_b;

    logic        in_ready_a, out_valid_a, rs1_en_a, rs2_en_a, rd_we_a, ill_a;
    logic [31:0] pc_a, imm_a;
    logic [4:0]  rs1_a, rs2_a, rd_a;
    logic [2:0]  fmt_a;

    logic        in_ready_b, out_valid_b, rs1_en_b, rs2_en_b, rd_we_b, ill_b;
    logic [63:0] pc_b, imm_b;
    logic [4:0]  rs1_b, rs2_b, rd_b;
    logic [2:0]  fmt_b;

    int n_checks = 0;
    int n_pass   = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t act_a, act_b;

    decode_unit #(.XLEN(32), .DEPTH(2)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_inst(in_inst), .in_pc(in_pc[31:0]),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_pc(pc_a),
        .out_rs1(rs1_a), .out_rs2(rs2_a), .out_rd(rd_a),
        .out_rs1_en(rs1_en_a), .out_rs2_en(rs2_en_a), .out_rd_we(rd_we_a),
        .out_imm(imm_a), .out_fmt(fmt_a), .out_illegal(ill_a)
    );

    decode_unit #(.XLEN(64), .DEPTH(2)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_pc(pc_b),
        .out_rs1(rs1_b), .out_rs2(rs2_b), .out_rd(rd_b),
        .out_rs1_en(rs1_en_b), .out_rs2_en(rs2_en_b), .out_rd_we(rd_we_b),
        .out_imm(imm_b), .out_fmt(fmt_b), .out_illegal(ill_b)
    );

    assign act_a = '{{32'd0, pc_a}, {32'd0, imm_a}, rs1_a, rs2_a, rd_a,
                     rs1_en_a, rs2_en_a, rd_we_a, fmt_a, ill_a};
    assign act_b = '{pc_b, imm_b, rs1_b, rs2_b, rd_b,
                     rs1_en_b, rs2_en_b, rd_we_b, fmt_b, ill_b};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [63:0] pc, input logic [63:0] imm,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic en1, input logic en2,
                                input logic we, input logic [2:0] fmt, input logic ill);
        exp_t e;
        e = '{pc, imm, rs1, rs2, rd, en1, en2, we, fmt, ill};
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    task automatic chk_e(input string name, input exp_t act, input exp_t req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    // Scoreboard monitors: compare the head whenever a transfer happens,
    // and require an all-zero head whenever nothing is valid.
    always @(negedge clk) begin
        if (out_valid_a && out_ready) begin
            if (qa.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_a: got entry pc %h, required no entry", pc_a);
            end else chk_e("entry_a", act_a, qa.pop_front());
        end else if (!out_valid_a) chk_e("idle_zero_a", act_a, '0);
    end

    always @(negedge clk) begin
        if (out_valid_b && out_ready) begin
            if (qb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_b: got entry pc %h, required no entry", pc_b);
            end else chk_e("entry_b", act_b, qb.pop_front());
        end else if (!out_valid_b) chk_e("idle_zero_b", act_b, '0);
    end

    // Presents one instruction to instance sel (0: XLEN=32, 1: XLEN=64) and
    // returns #1 after the accepting edge.
    task automatic send(input int sel, input logic [31:0] inst, input logic [63:0] pc,
                        input exp_t e);
        bit   done;
        exp_t em;
        done = 1'b0;
        em   = e;
        in_inst = inst;
        in_pc   = pc;
        if (sel == 0) in_valid_a = 1'b1; else in_valid_b = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if ((sel == 0) ? in_ready_a : in_ready_b) begin
                if (sel == 0) begin
                    em.pc[63:32]  = '0;
                    em.imm[63:32] = '0;
                    qa.push_back(em);
                end else qb.push_back(em);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL send_timeout: inst %h never accepted, required accept within 50 cycles", inst);
        end
    endtask

    initial begin
        time t0;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid_a = 1'b0; in_valid_b = 1'b0; in_inst = '0; in_pc = '0;
        #1;
        chk("rst_out_valid_a", 64'(out_valid_a), 64'd0);
        chk("rst_in_ready_a",  64'(in_ready_a),  64'd1);
        chk("rst_in_ready_b",  64'(in_ready_b),  64'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;

        // addi x1,x0,-1 and exact one-cycle latency
        send(0, 32'hFFF00093, 64'h100,
             mk(64'h100, {64{1'b1}}, 5'd0, 5'd0, 5'd1, 1, 0, 1, 3'd1, 0));
        @(negedge clk);
        chk("latency_out_valid", 64'(out_valid_a), 64'd1);
        @(posedge clk); #1;

        // Back-to-back stream across every format, one per cycle
        t0 = $time;
        send(0, 32'h002081B3, 64'h104, mk(64'h104, 64'd0, 5'd1, 5'd2, 5'd3, 1, 1, 1, 3'd0, 0));
        send(0, 32'h00112223, 64'h108, mk(64'h108, 64'd4, 5'd2, 5'd1, 5'd0, 1, 1, 0, 3'd2, 0));
        send(0, 32'hFE000EE3, 64'h10C, mk(64'h10C, 64'hFFFF_FFFF_FFFF_FFFC, 5'd0, 5'd0, 5'd0, 1, 1, 0, 3'd3, 0));
        send(0, 32'h123450B7, 64'h110, mk(64'h110, 64'h1234_5000, 5'd0, 5'd0, 5'd1, 0, 0, 1, 3'd4, 0));
        send(0, 32'h0000006F, 64'h114, mk(64'h114, 64'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 3'd5, 0));
        send(0, 32'h00000000, 64'h118, mk(64'h118, 64'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 3'd7, 1));
        send(0, 32'h0000007F, 64'h11C, mk(64'h11C, 64'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 3'd7, 1));
        send(0, 32'hFFF00091, 64'h120, mk(64'h120, 64'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 3'd7, 1));
        chk("throughput_time", 64'($time - t0), 64'd80);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: two fill the buffer, the third waits until release
        out_ready = 1'b0;
        send(0, 32'hFFF00093, 64'h200, mk(64'h200, {64{1'b1}}, 5'd0, 5'd0, 5'd1, 1, 0, 1, 3'd1, 0));
        send(0, 32'h002081B3, 64'h204, mk(64'h204, 64'd0, 5'd1, 5'd2, 5'd3, 1, 1, 1, 3'd0, 0));
        fork
            send(0, 32'h123450B7, 64'h208, mk(64'h208, 64'h1234_5000, 5'd0, 5'd0, 5'd1, 0, 0, 1, 3'd4, 0));
            begin
                @(negedge clk);
                chk("full_in_ready", 64'(in_ready_a), 64'd0);
                chk("full_head_pc",  64'(pc_a), 64'h200);
                repeat (2) @(negedge clk);
                chk("stall_out_valid", 64'(out_valid_a), 64'd1);
                chk("stall_head_imm",  64'(imm_a), 64'hFFFF_FFFF);
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // Flush with the buffer full and a pending input
        out_ready = 1'b0;
        send(0, 32'hFFF00093, 64'h300, mk(64'h300, {64{1'b1}}, 5'd0, 5'd0, 5'd1, 1, 0, 1, 3'd1, 0));
        send(0, 32'hFFF00093, 64'h304, mk(64'h304, {64{1'b1}}, 5'd0, 5'd0, 5'd1, 1, 0, 1, 3'd1, 0));
        in_inst = 32'h002081B3; in_pc = 64'h308; in_valid_a = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid_a = 1'b0;
        qa.delete();
        @(negedge clk);
        chk("flush_full_out_valid", 64'(out_valid_a), 64'd0);
        chk("flush_full_in_ready",  64'(in_ready_a),  64'd1);

        // Flush with one entry and a push that is allowed by in_ready
        @(posedge clk); #1;
        send(0, 32'hFFF00093, 64'h310, mk(64'h310, {64{1'b1}}, 5'd0, 5'd0, 5'd1, 1, 0, 1, 3'd1, 0));
        in_inst = 32'h002081B3; in_pc = 64'h314; in_valid_a = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid_a = 1'b0;
        qa.delete();
        @(negedge clk);
        chk("flush_push_discarded", 64'(out_valid_a), 64'd0);
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Asynchronous reset mid-cycle with one entry buffered
        out_ready = 1'b0;
        send(0, 32'hFFF00093, 64'h400, mk(64'h400, {64{1'b1}}, 5'd0, 5'd0, 5'd1, 1, 0, 1, 3'd1, 0));
        @(negedge clk);
        chk("pre_rst_out_valid", 64'(out_valid_a), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 64'(out_valid_a), 64'd0);
        chk("async_rst_in_ready",  64'(in_ready_a),  64'd1);
        qa.delete();
        #3 rst = 1'b0;
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // XLEN=64: sign extension of J and U immediates
        send(1, 32'hFFDFF0EF, 64'h8000_0000_0000_1000,
             mk(64'h8000_0000_0000_1000, 64'hFFFF_FFFF_FFFF_FFFC, 5'd0, 5'd0, 5'd1, 0, 0, 1, 3'd5, 0));
        send(1, 32'h800000B7, 64'h8000_0000_0000_1004,
             mk(64'h8000_0000_0000_1004, 64'hFFFF_FFFF_8000_0000, 5'd0, 5'd0, 5'd1, 0, 0, 1, 3'd4, 0));
        repeat (4) @(posedge clk);
        #1;

        chk("drained_a", 64'(qa.size()), 64'd0);
        chk("drained_b", 64'(qb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
